alu_nibble_seq: RTL

- Multi-cycle controller that runs WIDTH-bit ALU operations through a single ALU4Bit slice, one nibble per cycle, LSB nibble first.
- Holds the inter-nibble carry in a register and assembles the word result, flags and set-less-than.
- Sits between a requester using a start/done handshake and the shared 4-bit ALU datapath.
- Lets the team build 8/16/32-bit operations without widening the combinational ALU.

---
 rtl/alu_seq_pkg.sv | 24 ++
 rtl/alu_nibble_seq_alu4bit.sv | 36 +++
 rtl/alu_nibble_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the nibble-serial ALU sequencer: op codes, FSM states
// and the slice width.
package alu_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SLT  = 3'b011,
    OP_ANDN = 3'b100,
    OP_ORN  = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLTS = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_nibble_seq_alu4bit.sv
// Combinational 4-bit ALU slice: AND/OR/ADD/LESS with b-invert and carry in.
module ALU4Bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [2:0] i_op,
  input  logic       i_cin,
  input  logic       i_less,
  output logic [3:0] o_result,
  output logic       o_cout,
  output logic       o_overflow,
  output logic       o_set
);

  logic [3:0] w_bx;
  logic [4:0] w_sum;
  logic       w_c3;

  assign w_bx  = i_op[2] ? ~i_b : i_b;
  assign w_sum = {1'b0, i_a} + {1'b0, w_bx} + {4'b0000, i_cin};
  // carry into the MSB recovered from the MSB sum bit
  assign w_c3       = i_a[3] ^ w_bx[3] ^ w_sum[3];
  assign o_cout     = w_sum[4];
  assign o_overflow = w_c3 ^ w_sum[4];
  assign o_set      = w_sum[3];

  always_comb begin
    o_result = 4'h0;
    case (i_op[1:0])
      2'b00:   o_result = i_a & w_bx;
      2'b01:   o_result = i_a | w_bx;
      2'b10:   o_result = w_sum[3:0];
      default: o_result = {3'b000, i_less};
    endcase
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// Runs a WIDTH-bit ALU operation through one 4-bit slice, LSB nibble first,
// carrying between nibbles in a register and assembling result and flags.
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int NIB   = WIDTH / NIB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_e           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic [2:0]       r_op;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry, r_cout, r_ovf, r_zero;

  logic [IDX_W+1:0] w_sh;
  logic [3:0]       w_nib_a, w_nib_b, w_nib_res;
  logic [2:0]       w_slice_op;
  logic             w_nib_cout, w_nib_ovf, w_nib_set;
  logic             w_is_slt, w_arith, w_last;
  logic [WIDTH-1:0] w_word, w_final;

  assign w_sh       = {r_idx, 2'b00};
  assign w_nib_a    = r_a[w_sh +: 4];
  assign w_nib_b    = r_b[w_sh +: 4];
  assign w_is_slt   = (r_op[1:0] == 2'b11);
  assign w_arith    = (r_op[1:0] == 2'b10);
  assign w_last     = (r_idx == LAST_IDX);
  // SLT runs as a full subtract; the less input is never selected
  assign w_slice_op = w_is_slt ? OP_SUB : r_op;

  ALU4Bit u_slice (
    .i_a        (w_nib_a),
    .i_b        (w_nib_b),
    .i_op       (w_slice_op),
    .i_cin      (r_carry),
    .i_less     (1'b0),
    .o_result   (w_nib_res),
    .o_cout     (w_nib_cout),
    .o_overflow (w_nib_ovf),
    .o_set      (w_nib_set)
  );

  assign w_word  = (r_result & ~(WIDTH'(4'hF) << w_sh)) | (WIDTH'(w_nib_res) << w_sh);
  assign w_final = w_is_slt ? WIDTH'(w_nib_set ^ w_nib_ovf) : w_word;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end

  // operand capture: datapath only, no reset needed
  always_ff @(posedge clk) begin
    if (r_state == IDLE && start) begin
      r_a  <= a;
      r_b  <= b;
      r_op <= op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_idx   <= '0;
          r_carry <= op[2] | (op[1] & op[0]);
        end
        RUN: begin
          r_carry <= w_nib_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_result <= w_final;
            r_zero   <= (w_final == '0);
            r_cout   <= w_arith & w_nib_cout;
            r_ovf    <= w_arith & w_nib_ovf;
          end else begin
            r_result <= w_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_ovf;
  assign zero     = r_zero;

endmodule
